// File: rtl/my_types_pkg.sv
// Shared types for the dual-core decode path: word and extension-code types,
// plus the core identifier used by the immediate-extender arbiter.
package my_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ZERO_EXT = 2'b00,
        SIGN_EXT = 2'b01,
        LUI_EXT  = 2'b10
    } ext_code_t;

    typedef logic core_id_t;

    localparam int EXT_NUM_REQ = 2;

endpackage

// File: rtl/sign_extender.sv
// Shared immediate extender: widens a 16-bit immediate to a 32-bit word
// according to the extension code. Code 2'b11 replicates the immediate.
module sign_extender
    import my_types_pkg::*;
(
    input  logic [15:0] imm,
    input  ext_code_t   code,
    output word_t       ext
);

    // Extension selection
    always_comb begin
        ext = 32'h0000_0000;
        case (code)
            ZERO_EXT: ext = {16'h0000, imm};
            SIGN_EXT: ext = {{16{imm[15]}}, imm};
            LUI_EXT:  ext = {imm, 16'h0000};
            default:  ext = {imm, imm};
        endcase
    end

endmodule

// File: rtl/ext_arbiter.sv
// Arbitrates the shared sign_extender between two cores with one-entry result
// registers. Define EXT_ARB_FIXED_PRIO_EN for fixed core-0 priority instead of round-robin.
module ext_arbiter
    import my_types_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] imm0,
    input  logic [15:0] imm1,
    input  logic [1:0]  code0,
    input  logic [1:0]  code1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    input  logic        rready0,
    input  logic        rready1
);

    logic [EXT_NUM_REQ-1:0] elig_s;
    logic [EXT_NUM_REQ-1:0] gnt_s;
    logic                   rvalid0_r;
    logic                   rvalid1_r;
    word_t                  rdata0_r;
    word_t                  rdata1_r;
    core_id_t               sel_s;
    logic [15:0]            ext_imm_s;
    ext_code_t              ext_code_s;
    word_t                  ext_out_s;

`ifndef EXT_ARB_FIXED_PRIO_EN
    core_id_t               last_r;
`endif

    // A slot draining this cycle can take a new result in the same cycle
    assign elig_s[0] = req0 & (~rvalid0_r | rready0);
    assign elig_s[1] = req1 & (~rvalid1_r | rready1);

    // Grant selection; forced idle while reset is asserted
    always_comb begin
        gnt_s = 2'b00;
        if (RST) begin
            gnt_s = 2'b00;
        end else if (elig_s == 2'b11) begin
`ifdef EXT_ARB_FIXED_PRIO_EN
            gnt_s = 2'b01;
`else
            if (last_r == 1'b1) begin
                gnt_s = 2'b01;
            end else begin
                gnt_s = 2'b10;
            end
`endif
        end else begin
            gnt_s = elig_s;
        end
    end

    assign gnt0 = gnt_s[0];
    assign gnt1 = gnt_s[1];

    assign sel_s      = gnt_s[1];
    assign ext_imm_s  = (sel_s == 1'b1) ? imm1 : imm0;
    assign ext_code_s = (sel_s == 1'b1) ? ext_code_t'(code1) : ext_code_t'(code0);

    sign_extender u_sign_extender (
        .imm  (ext_imm_s),
        .code (ext_code_s),
        .ext  (ext_out_s)
    );

    // Core 0 result register: a new grant wins over a same-cycle drain
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rvalid0_r <= 1'b0;
            rdata0_r  <= 32'h0000_0000;
        end else if (gnt_s[0]) begin
            rvalid0_r <= 1'b1;
            rdata0_r  <= ext_out_s;
        end else if (rready0) begin
            rvalid0_r <= 1'b0;
        end else begin
            rvalid0_r <= rvalid0_r;
        end
    end

    // Core 1 result register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rvalid1_r <= 1'b0;
            rdata1_r  <= 32'h0000_0000;
        end else if (gnt_s[1]) begin
            rvalid1_r <= 1'b1;
            rdata1_r  <= ext_out_s;
        end else if (rready1) begin
            rvalid1_r <= 1'b0;
        end else begin
            rvalid1_r <= rvalid1_r;
        end
    end

`ifndef EXT_ARB_FIXED_PRIO_EN
    // Most recently granted core; reset value lets core 0 win the first tie
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_r <= 1'b1;
        end else if (gnt_s != 2'b00) begin
            last_r <= sel_s;
        end else begin
            last_r <= last_r;
        end
    end
`endif

    assign rvalid0 = rvalid0_r;
    assign rvalid1 = rvalid1_r;
    assign rdata0  = rdata0_r;
    assign rdata1  = rdata1_r;

endmodule

// File: tb/tb_ext_arbiter.sv
// Self-checking bench for ext_arbiter: directed scenarios followed by random
// traffic, all compared against a behavioural model of the arbitration rules.
module tb_ext_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] imm0 = 16'h0, imm1 = 16'h0;
    logic [1:0]  code0 = 2'b00, code1 = 2'b00;
    logic        rready0 = 1'b0, rready1 = 1'b0;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;

    int checks = 0;
    int failures = 0;

    // behavioural model state
    bit          mv [2];
    logic [31:0] md [2];
    int          mlast = 1;

    ext_arbiter dut (
        .CLK(clk), .RST(rst),
        .req0(req0), .req1(req1),
        .imm0(imm0), .imm1(imm1),
        .code0(code0), .code1(code1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .rready0(rready0), .rready1(rready1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_ext(input logic [1:0] c, input logic [15:0] i);
        int unsigned v;
        v = i;
        case (c)
            2'd0:    return v;
            2'd1:    return (v >= 32768) ? v + 32'hFFFF0000 : v;
            2'd2:    return v * 65536;
            default: return v * 65536 + v;
        endcase
    endfunction

    function automatic int pick(input bit e0, input bit e1);
        if (e0 && e1) begin
`ifdef EXT_ARB_FIXED_PRIO_EN
            return 0;
`else
            return (mlast == 0) ? 1 : 0;
`endif
        end
        if (e0) return 0;
        if (e1) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        mv[0] = 1'b0; mv[1] = 1'b0;
        md[0] = 32'h0; md[1] = 32'h0;
        mlast = 1;
    endtask

    // One clock: drive after negedge, check grants, then check results after posedge
    task automatic cyc(input bit r0, input bit r1, input logic [15:0] i0, input logic [15:0] i1,
                       input logic [1:0] c0, input logic [1:0] c1, input bit rr0, input bit rr1);
        int g;
        bit e0, e1;
        req0 = r0; req1 = r1; imm0 = i0; imm1 = i1;
        code0 = c0; code1 = c1; rready0 = rr0; rready1 = rr1;
        #1;
        e0 = r0 && (!mv[0] || rr0);
        e1 = r1 && (!mv[1] || rr1);
        g = pick(e0, e1);
        chk("gnt0", {31'b0, gnt0}, {31'b0, g == 0});
        chk("gnt1", {31'b0, gnt1}, {31'b0, g == 1});
        @(posedge clk); #1;
        if (g == 0) begin mv[0] = 1'b1; md[0] = ref_ext(c0, i0); end
        else if (rr0) mv[0] = 1'b0;
        if (g == 1) begin mv[1] = 1'b1; md[1] = ref_ext(c1, i1); end
        else if (rr1) mv[1] = 1'b0;
        if (g >= 0) mlast = g;
        chk("rvalid0", {31'b0, rvalid0}, {31'b0, mv[0]});
        chk("rvalid1", {31'b0, rvalid1}, {31'b0, mv[1]});
        chk("rdata0", rdata0, md[0]);
        chk("rdata1", rdata1, md[1]);
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        req0 = 1'b1; req1 = 1'b1;
        repeat (2) @(negedge clk);
        // reset state, grants forced low under reset
        chk("rst_gnt0", {31'b0, gnt0}, 32'h0);
        chk("rst_gnt1", {31'b0, gnt1}, 32'h0);
        chk("rst_rvalid0", {31'b0, rvalid0}, 32'h0);
        chk("rst_rdata1", rdata1, 32'h0);
        rst = 1'b0;

        // 1: sign extension on core 0
        cyc(1, 0, 16'h8001, 16'h0, 2'd1, 2'd0, 0, 0);
        chk("t1_rdata0", rdata0, 32'hFFFF8001);
        cyc(0, 0, 16'h0, 16'h0, 2'd0, 2'd0, 1, 1);

        // 2: continuous contention with draining
        for (int k = 0; k < 6; k++)
            cyc(1, 1, 16'h1234, 16'h00FF, 2'd0, 2'd2, 1, 1);
        chk("t2_rdata0", rdata0, 32'h00001234);
        chk("t2_rdata1", rdata1, 32'h00FF0000);
        cyc(0, 0, 16'h0, 16'h0, 2'd0, 2'd0, 1, 1);

        // 3: core 0 full and not draining, core 1 may proceed
        cyc(1, 0, 16'h5555, 16'h0, 2'd0, 2'd0, 0, 0);
        cyc(1, 1, 16'h5555, 16'h7777, 2'd0, 2'd0, 0, 1);
        cyc(1, 1, 16'h6666, 16'h7777, 2'd1, 2'd0, 1, 1);
        chk("t3_rdata0", rdata0, 32'h00006666);

        // 4: undefined code replicates the immediate
        cyc(0, 1, 16'h0, 16'hABCD, 2'd0, 2'b11, 1, 1);
        chk("t4_rdata1", rdata1, 32'hABCDABCD);

        // 5: asynchronous reset mid-cycle with a pending result
        cyc(1, 0, 16'h4321, 16'h0, 2'd0, 2'd0, 0, 0);
        req0 = 1'b1; req1 = 1'b1; rready0 = 1'b0; rready1 = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t5_rvalid0", {31'b0, rvalid0}, 32'h0);
        chk("t5_rdata0", rdata0, 32'h0);
        chk("t5_gnt0", {31'b0, gnt0}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cyc(1, 1, 16'h0011, 16'h0022, 2'd0, 2'd0, 1, 1);
        chk("t5_tie_rdata0", rdata0, 32'h00000011);

        // random traffic
        for (int k = 0; k < 300; k++)
            cyc($urandom_range(0, 1), $urandom_range(0, 1), 16'($urandom), 16'($urandom),
                2'($urandom), 2'($urandom), $urandom_range(0, 1), $urandom_range(0, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ext_arbiter.md
# ext_arbiter

Shares the single immediate extender between the two cores' decode stages in the dual-core design. Each core presents a 16-bit immediate plus an extension code; the arbiter grants at most one request per cycle and drives the shared `sign_extender`. It holds each core's 32-bit result in a per-core one-entry result register under a valid/ready handshake. Round-robin arbitration keeps either core from starving the other.

## Interface
- Parameters: none. Widths are fixed by `word_t` (32 bits) and `ext_code_t` (2 bits).
- `CLK` in 1 — single clock, rising edge.
- `RST` in 1 — asynchronous, active-high reset.
- `req0`, `req1` in 1 — core N requests an extension this cycle.
- `imm0`, `imm1` in 16 — core N immediate.
- `code0`, `code1` in `ext_code_t` — core N extension code.
- `gnt0`, `gnt1` out 1 — combinational; core N's request is accepted this cycle. At most one is high per cycle.
- `rvalid0`, `rvalid1` out 1 — core N result register holds a valid result.
- `rdata0`, `rdata1` out `word_t` — core N result.
- `rready0`, `rready1` in 1 — core N consumes its result this cycle.

## Operation
- Eligibility: `elig[N] = req[N] & (!rvalid[N] | rready[N])`. A slot that drains in the same cycle can accept a new request.
- State register `last` (1 bit) records the most recently granted core.
- Grant rules:
  - Only one core eligible: grant it.
  - Both eligible: grant the core that is not `last`.
  - Neither eligible: no grant, and `last` is unchanged.
- On a grant to core N:
  - Mux `imm[N]`/`code[N]` into the extender.
  - Capture its output into result register N.
  - Set `rvalid[N]`.
  - Set `last = N`.
- Extension codes:
  - `ZERO_EXT` (00) → `{16'h0, imm}`.
  - `SIGN_EXT` (01) → `{{16{imm[15]}}, imm}`.
  - `LUI_EXT` (10) → `{imm, 16'h0}`.
  - Code 11 is undefined; the result is `{imm, imm}`, with no error flag.
- Drain: `rready[N]` with `rvalid[N]` high and no new grant to N clears `rvalid[N]`. `rdata[N]` holds its last value.
- `rready[N]` while `rvalid[N]` is low has no effect.
- Requesters hold `req`/`imm`/`code` stable until granted. The arbiter does not latch ungranted requests.

## Timing
- Reset values: `rvalid0 = rvalid1 = 0`, `rdata0 = rdata1 = 32'h0`, `last = 1` (core 0 wins the first tie).
- `gnt` outputs are combinational from `req`, `rvalid`, `rready` and `last`. Under reset they are forced to 0.
- Latency: a grant in cycle T gives `rvalid`/`rdata` valid from cycle T+1.
- Throughput: one extension per cycle in total. Each core gets at most one per cycle while it drains every cycle.
- Contention: with both cores requesting continuously and draining every cycle, grants alternate 0,1,0,1,…
- Simultaneous drain and grant on core N: the new result overwrites, and `rvalid[N]` stays 1.
- Result register full and not draining: `gnt[N] = 0`. The other core may be granted that cycle.
- `RST` asserted mid-operation:
  - Pending results are discarded immediately (asynchronous).
  - `last` returns to 1.
  - Requests held across reset are arbitrated fresh after deassertion.

## Configuration
- `EXT_ARB_FIXED_PRIO_EN`
  - Defined: when both cores are eligible, core 0 always wins. `last` is neither implemented nor used.
  - Undefined (default): round-robin as above.
  - All other behaviour is identical.

## Structure
- `ext_code_t` (`ZERO_EXT`, `SIGN_EXT`, `LUI_EXT`) and `word_t` come from the shared packages.
- Add to `my_types_pkg`: `typedef logic core_id_t;`, used for `last` and the grant index.
- Add to `my_types_pkg`: constant `EXT_NUM_REQ = 2`.
- Sub-module: one instance of the existing `sign_extender`, fed by the grant-selected immediate and code. No other sub-modules.

## Test plan
1. Reset, then `req0=1, imm0=16'h8001, code0=SIGN_EXT`.
   - Required: `gnt0=1` in the same cycle.
   - Next cycle: `rvalid0=1`, `rdata0=32'hFFFF8001`.
2. Both cores request every cycle, `rready0=rready1=1`, `imm0=16'h1234/ZERO_EXT`, `imm1=16'h00FF/LUI_EXT`.
   - Required: grants alternate 0,1,0,….
   - Results: `rdata0=32'h00001234`, `rdata1=32'h00FF0000`.
3. Core 0 result pending with `rready0=0`; both request.
   - Required: `gnt0=0`, `gnt1=1`.
   - After `rready0=1`, core 0 is granted the following cycle.
4. `code1=2'b11, imm1=16'hABCD`.
   - Required: `rdata1=32'hABCDABCD`.
5. `RST` pulsed mid-cycle while `rvalid0=1`.
   - Required: `rvalid0` drops asynchronously.
   - After release, a tie is granted to core 0.
6. With `EXT_ARB_FIXED_PRIO_EN` defined and both requesting continuously with draining:
   - Required: `gnt0=1` every cycle, `gnt1` never asserted.
